// File: rtl/tdc_seq_pkg.sv
// Shared types and constants for the TDC byte sequencer.
// TDC_SEQ_XOR_EN adds the checksum state to the state enum.
package tdc_seq_pkg;

  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
`ifdef TDC_SEQ_XOR_EN
    , S_XOR = 2'd3
`endif
  } tdc_seq_state_t;

  // Bytes per frame: header, data bytes, optional checksum.
  function automatic int frame_bytes(input int word_w, input bit xor_en);
    return 1 + word_w / 8 + (xor_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/tdc_byte_sequencer_if.sv
// Word-in / byte-out bundle between the event source, sequencer and latch stage.
interface tdc_byte_sequencer_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic [7:0]        byte_out;
  logic              byte_en;
  logic              byte_last;
  logic              busy;

  modport master (
    output word_in, word_valid,
    input  word_ready, byte_out, byte_en, byte_last, busy
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, byte_out, byte_en, byte_last, busy
  );
endinterface

// File: rtl/tdc_pace_ctr.sv
// Loadable down-counter; tick is high whenever the count has run out.
module tdc_pace_ctr #(
  parameter int PACE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  output logic tick
);
  localparam int PW = $clog2(PACE + 1);

  logic [PW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= PW'(PACE - 1);
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - PW'(1);
    end
  end

  assign tick = (cnt_reg == '0);

endmodule

// File: rtl/tdc_byte_sequencer.sv
// Serialises one TDC event word into a paced header/data[/checksum] byte frame.
// Define TDC_SEQ_XOR_EN to append the XOR checksum byte.
module tdc_byte_sequencer
  import tdc_seq_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int PACE   = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  tdc_byte_sequencer_if.slave bus
);
  localparam int NB = WORD_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);

  tdc_seq_state_t    state_reg;
  logic [WORD_W-1:0] shift_reg;
  logic [3:0]        evt_cnt_reg;
  logic [3:0]        evt_snap_reg;
  logic [CW-1:0]     byte_cnt_reg;
  logic              ready_reg;
  logic [7:0]        byte_reg;
  logic              en_reg;
  logic              last_reg;
  logic              busy_reg;
  logic              tick;
  logic              strobe;
  logic [7:0]        hdr_byte;
  logic [7:0]        top_byte;
`ifdef TDC_SEQ_XOR_EN
  logic [7:0]        acc_reg;
`endif

  assign hdr_byte = {HDR_TAG, evt_snap_reg};
  assign top_byte = shift_reg[WORD_W-1 -: 8];
  // Every byte emitted outside IDLE coincides with a pace tick and reloads it.
  assign strobe   = (state_reg != S_IDLE) && tick;

  tdc_pace_ctr #(.PACE(PACE)) u_pace (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_reg == S_IDLE),
    .load  (strobe),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      shift_reg    <= '0;
      evt_cnt_reg  <= '0;
      evt_snap_reg <= '0;
      byte_cnt_reg <= '0;
      ready_reg    <= 1'b0;
      byte_reg     <= 8'h00;
      en_reg       <= 1'b0;
      last_reg     <= 1'b0;
      busy_reg     <= 1'b0;
`ifdef TDC_SEQ_XOR_EN
      acc_reg      <= 8'h00;
`endif
    end else begin
      en_reg   <= 1'b0;
      last_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          busy_reg <= 1'b0;
          if (bus.word_valid && ready_reg) begin
            shift_reg    <= bus.word_in;
            evt_snap_reg <= evt_cnt_reg;
            evt_cnt_reg  <= evt_cnt_reg + 4'd1;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= S_HDR;
          end else begin
            ready_reg <= 1'b1;
          end
        end
        S_HDR: begin
          if (tick) begin
            byte_reg     <= hdr_byte;
            en_reg       <= 1'b1;
            byte_cnt_reg <= LAST_IDX;
`ifdef TDC_SEQ_XOR_EN
            acc_reg      <= hdr_byte;
`endif
            state_reg    <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            byte_reg  <= top_byte;
            en_reg    <= 1'b1;
            shift_reg <= shift_reg << 8;
`ifdef TDC_SEQ_XOR_EN
            acc_reg   <= acc_reg ^ top_byte;
`endif
            if (byte_cnt_reg == '0) begin
`ifdef TDC_SEQ_XOR_EN
              state_reg <= S_XOR;
`else
              last_reg  <= 1'b1;
              state_reg <= S_IDLE;
`endif
            end else begin
              byte_cnt_reg <= byte_cnt_reg - CW'(1);
            end
          end
        end
`ifdef TDC_SEQ_XOR_EN
        S_XOR: begin
          if (tick) begin
            byte_reg  <= acc_reg;
            en_reg    <= 1'b1;
            last_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
`endif
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.word_ready = ready_reg;
  assign bus.byte_out   = byte_reg;
  assign bus.byte_en    = en_reg;
  assign bus.byte_last  = last_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_tdc_byte_sequencer.sv
// Scoreboard bench for two sequencer instances (32-bit/PACE=1 and 8-bit/PACE=3).
// Honours TDC_SEQ_XOR_EN for the expected checksum byte.
module tb_tdc_byte_sequencer;
  localparam int W0 = 32;
  localparam int P0 = 1;
  localparam int W1 = 8;
  localparam int P1 = 3;
`ifdef TDC_SEQ_XOR_EN
  localparam bit XEN = 1'b1;
`else
  localparam bit XEN = 1'b0;
`endif

  typedef struct {
    logic [7:0] b;
    logic       l;
    int         c;
  } exp_t;

  logic clk = 1'b0;
  logic rst0_n;
  logic rst1_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [3:0] evt[2];
  bit   ready_chk[2];

  tdc_byte_sequencer_if #(.WORD_W(W0)) b0 ();
  tdc_byte_sequencer_if #(.WORD_W(W1)) b1 ();

  tdc_byte_sequencer #(.WORD_W(W0), .PACE(P0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst0_n),
    .bus   (b0)
  );

  tdc_byte_sequencer #(.WORD_W(W1), .PACE(P1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? b0.word_ready : b1.word_ready;
  endfunction

  function automatic logic bsy(input int d);
    return (d == 0) ? b0.busy : b1.busy;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Expected frame for a word accepted on the edge that makes cyc == a.
  task automatic push(input int d, input logic [31:0] w, input int a);
    int nb;
    int p;
    logic [7:0] x;
    logic [7:0] bt;
    exp_t e;
    nb = (d == 0) ? W0 / 8 : W1 / 8;
    p  = (d == 0) ? P0 : P1;
    x  = {4'hA, evt[d]};
    e.b = x; e.l = 1'b0; e.c = a + 1;
    qpush(d, e);
    evt[d] = evt[d] + 4'd1;
    for (int k = 1; k <= nb; k++) begin
      bt  = w[8*(nb-k) +: 8];
      x   = x ^ bt;
      e.b = bt; e.l = (!XEN && k == nb); e.c = a + 1 + p * k;
      qpush(d, e);
    end
    if (XEN) begin
      e.b = x; e.l = 1'b1; e.c = a + 1 + p * (nb + 1);
      qpush(d, e);
    end
  endtask

  task automatic mon(input int d);
    logic en;
    logic lst;
    logic [7:0] bo;
    bit have;
    exp_t e;
    en  = (d == 0) ? b0.byte_en   : b1.byte_en;
    lst = (d == 0) ? b0.byte_last : b1.byte_last;
    bo  = (d == 0) ? b0.byte_out  : b1.byte_out;
    if (ready_chk[d]) begin
      ready_chk[d] = 1'b0;
      check($sformatf("ready_after_last%0d", d), 32'(rdy(d)), 1);
      check($sformatf("busy_after_last%0d", d), 32'(bsy(d)), 0);
    end
    if (en === 1'b1) begin
      have = (qsize(d) != 0);
      check($sformatf("strobe_expected%0d", d), 32'(have), 1);
      if (have) begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("byte%0d", d), 32'(bo), 32'(e.b));
        check($sformatf("last%0d", d), 32'(lst), 32'(e.l));
        check($sformatf("strobe_cycle%0d", d), 32'(cyc), 32'(e.c));
        check($sformatf("busy_in_frame%0d", d), 32'(bsy(d)), 1);
        if (e.l) ready_chk[d] = 1'b1;
      end
    end
  endtask

  initial forever begin @(negedge clk); mon(0); end
  initial forever begin @(negedge clk); mon(1); end

  // Drive a word and wait for acceptance; hold leaves word_valid asserted.
  task automatic send(input int d, input logic [31:0] w, input bit hold);
    bit ok;
    ok = 1'b0;
    if (d == 0) begin b0.word_in = w; b0.word_valid = 1'b1; end
    else begin b1.word_in = w[7:0]; b1.word_valid = 1'b1; end
    for (int i = 0; i < 400 && !ok; i++) begin
      if (rdy(d) === 1'b1) begin
        ok = 1'b1;
        push(d, w, cyc + 1);
      end
      @(negedge clk);
    end
    check($sformatf("accept%0d", d), 32'(ok), 1);
    check($sformatf("ready_low_after_accept%0d", d), 32'(rdy(d)), 0);
    check($sformatf("busy_after_accept%0d", d), 32'(bsy(d)), 1);
    if (!hold) begin
      if (d == 0) b0.word_valid = 1'b0;
      else        b1.word_valid = 1'b0;
    end
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 400; i++) begin
      if (qsize(d) == 0 && !ready_chk[d]) break;
      @(negedge clk);
    end
    check($sformatf("drain%0d", d), 32'(qsize(d)), 0);
  endtask

  task automatic check_zero(input int d, input string tag);
    if (d == 0) begin
      check({tag, "_byte_out"}, 32'(b0.byte_out), 0);
      check({tag, "_byte_en"}, 32'(b0.byte_en), 0);
      check({tag, "_byte_last"}, 32'(b0.byte_last), 0);
    end else begin
      check({tag, "_byte_out"}, 32'(b1.byte_out), 0);
      check({tag, "_byte_en"}, 32'(b1.byte_en), 0);
      check({tag, "_byte_last"}, 32'(b1.byte_last), 0);
    end
    check({tag, "_busy"}, 32'(bsy(d)), 0);
    check({tag, "_ready"}, 32'(rdy(d)), 0);
  endtask

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    b0.word_in = '0; b0.word_valid = 1'b0;
    b1.word_in = '0; b1.word_valid = 1'b0;
    evt[0] = 4'd0; evt[1] = 4'd0;
    ready_chk[0] = 1'b0; ready_chk[1] = 1'b0;

    repeat (3) @(negedge clk);
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset0", 32'(rdy(0)), 1);
    check("ready_after_reset1", 32'(rdy(1)), 1);

    // Basic frame: A0 12 34 56 78 [A8].
    send(0, 32'h12345678, 1'b0);
    drain(0);

    // Reset during the third strobe (header A1, DE, AD).
    send(0, 32'hDEADBEEF, 1'b0);
    repeat (3) @(negedge clk);
    check("third_strobe_en", 32'(b0.byte_en), 1);
    check("third_strobe_byte", 32'(b0.byte_out), 32'hAD);
    #1 rst0_n = 1'b0;
    q0.delete();
    ready_chk[0] = 1'b0;
    evt[0] = 4'd0;
    #1 check_zero(0, "midframe_reset");
    @(negedge clk);
    rst0_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(rdy(0)), 1);
    send(0, 32'hCAFEF00D, 1'b0);
    drain(0);

    // Seventeen back-to-back frames: event counter wraps AF -> A0.
    for (int i = 0; i < 17; i++) send(0, $urandom, 1'b0);
    drain(0);

    // PACE=3, 8-bit words; second word held valid while ready is low.
    send(1, 32'h5C, 1'b1);
    send(1, 32'hC3, 1'b0);
    drain(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tdc_byte_sequencer.md
# tdc_byte_sequencer

Upstream feeder for the 8-bit readout latch stage of the TDC readout path. Accepts one parallel TDC event word over a valid/ready handshake and emits it as a paced byte frame: a header byte, the data bytes MSB-first, and an optional checksum byte. Each byte is presented on `byte_out` together with a single-cycle `byte_en` strobe that drives the latch's enable. Pacing is fixed and the strobe has no backpressure; the downstream latch captures on every strobe.

## Interface
- `WORD_W`, 32, event word width; must be a multiple of 8 and at least 8.
- `PACE`, 2, clock cycles between consecutive `byte_en` pulses within a frame; must be at least 1.
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `word_in`  in  WORD_W  TDC event word.
- `word_valid`  in  1  `word_in` is valid.
- `word_ready`  out  1  registered; the block can accept a word.
- `byte_out`  out  8  current frame byte; holds its value between strobes.
- `byte_en`  out  1  one-cycle strobe marking `byte_out` as new.
- `byte_last`  out  1  high together with `byte_en` on the final byte of a frame.
- `busy`  out  1  high while a frame is in progress (from acceptance through the last byte).

## Operation
- **FSM states:** IDLE, HDR, DATA, XOR (XOR exists only with the macro).
- **Acceptance:** a word is accepted on a rising edge where `word_valid & word_ready` is high.
  - `word_in` is captured into a shift register.
  - The 4-bit event counter `evt_cnt` is snapshotted, then incremented. It wraps 15→0.
  - `word_ready` clears, and the state moves to HDR.
- **`word_valid` while `word_ready` is low:** ignored. No capture takes place.
- **HDR:** emits `{4'hA, evt_snapshot}`.
- **DATA:** emits `WORD_W/8` bytes, MSB first. The byte counter reloads at HDR.
- **XOR:** emits the XOR of the header byte and all data bytes.
- **Frame length:** 1 + WORD_W/8 bytes, plus 1 with the checksum. With WORD_W=32 that is 5 bytes, or 6.
- **`byte_last`:** asserted only with the final strobe of a frame.
- **After the final byte:** the state returns to IDLE, and `word_ready` rises on the same edge that clears `byte_en`.
- **Reset values:** `word_ready`=0, `byte_out`=8'h00, `byte_en`=0, `byte_last`=0, `busy`=0, state=IDLE, `evt_cnt`=0.
  - `word_ready` rises on the first clock edge after `rst_n` deasserts.
- **Reset mid-frame:** the frame is abandoned immediately with no partial-frame completion. The next frame carries header 8'hA0.

## Timing
- **Word accepted at edge N:**
  - Header strobe is high in the cycle after edge N+1.
  - Byte k (header = 0) is strobed PACE·k cycles after the header.
- **`byte_en` pulses:** always exactly 1 cycle wide; no two pulses are adjacent unless PACE=1.
- **Between frames:** the next header strobe comes at least 2 cycles after the last byte strobe. `word_ready` is high in the cycle directly following the last strobe.
- **`busy`:** rises on the acceptance edge and falls on the edge that raises `word_ready`.
- **Pace counter:** width $clog2(PACE+1). It reloads on every strobe and is held at 0 in IDLE.

## Configuration
- `TDC_SEQ_XOR_EN` defined: XOR state present; checksum byte appended; `byte_last` moves onto the checksum byte.
- `TDC_SEQ_XOR_EN` undefined: no XOR state or accumulator is built; the frame ends on the last data byte.
- All other behaviour is identical in both builds.

## Structure
- **Shared package `tdc_seq_pkg`** contains:
  - `HDR_TAG` = 4'hA;
  - the state enum `tdc_seq_state_t`;
  - the function `frame_bytes(WORD_W, xor_en)`.
- **Sub-module `tdc_pace_ctr`:** loadable down-counter with parameter PACE and output `tick`. It gates all byte advances.
- Shift register, byte counter, `evt_cnt`, XOR accumulator and FSM live in the top module.

## Test plan
- **Basic frame:** PACE=1, no macro. After reset, drive `word_in`=32'h12345678 with `word_valid`.
  - Strobes A0,12,34,56,78 on 5 consecutive cycles; `byte_last` on 78.
  - `word_ready` is high the next cycle.
- **Checksum frame:** same stimulus with `TDC_SEQ_XOR_EN`.
  - 6th byte is 8'hA8 with `byte_last`; the 78 strobe has `byte_last`=0.
- **Pacing and backpressure:** PACE=3. Hold `word_valid` high with a new word while `word_ready`=0.
  - Strobes are spaced exactly 3 cycles apart.
  - The second word is not captured until `word_ready` returns; its header is 8'hA1.
- **Counter wrap:** 17 back-to-back frames.
  - Headers run A0..AF, then A0; the minimum inter-frame gap of 2 cycles is met.
- **Reset mid-frame:** pull `rst_n` low during the third strobe.
  - All outputs read 0 immediately.
  - `word_ready`=1 one edge after release.
  - The next frame's header is 8'hA0.
- **Width variant:** WORD_W=8, PACE=1, input 8'h5C.
  - Frame is A0,5C; with the macro, the checksum is 8'hFC.
